counter_run_controller: RTL and testbench
=========================================

Name: counter_run_controller

Overview:
- Run/pause/clear/lap controller for the multi-digit counter display path.
- Turns debounced button pulses and the 1 Hz tick into counter enable/clear pulses.
- Sequences the multi-cycle binary-to-BCD converter through a start/done handshake and owns the display BCD register (lap freeze, pause blink).
- Sits between the clock dividers, the up counter, the converter and the 7-segment driver; single clock domain.

Parameters:
- WIDTH, 12, binary count width.
- MAX_COUNT, 4095, terminal count value.
- WRAP, 1, 1 = wrap to 0 after MAX_COUNT; 0 = halt at MAX_COUNT.
- CONV_TIMEOUT, 64, clk cycles allowed from conv_start to conv_done before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- tick  in  1  1-cycle count-rate enable pulse.
- btn_run  in  1  1-cycle debounced pulse; toggles run/pause.
- btn_clear  in  1  1-cycle debounced pulse; clears the count.
- btn_lap  in  1  1-cycle debounced pulse; toggles display freeze.
- count_in  in  WIDTH  current up-counter value; registered, valid 1 cycle after cnt_en/cnt_clr.
- conv_done  in  1  1-cycle converter completion pulse.
- conv_bcd  in  16  converter result, valid with conv_done.
- cnt_en  out  1  1-cycle increment pulse to the counter.
- cnt_clr  out  1  1-cycle synchronous clear pulse to the counter.
- conv_start  out  1  1-cycle converter start pulse.
- conv_bin  out  WIDTH  operand held stable from conv_start until done/abort.
- disp_bcd  out  16  BCD value to the display driver.
- disp_blank  out  1  blank all digits.
- running  out  1  main FSM in ST_RUN.
- frozen  out  1  lap freeze active.
- conv_err  out  1  sticky converter-timeout flag; cleared by btn_clear.

Behaviour:
- Reset (rst low, async): all outputs 0, main FSM ST_IDLE, conv FSM CV_IDLE, conv_pend=1 so the first conversion runs right after reset release.
- Main FSM states: ST_IDLE, ST_RUN, ST_PAUSE, ST_HALT.
- ST_IDLE:
  - btn_run -> ST_RUN.
  - tick ignored.
- ST_RUN:
  - tick -> cnt_en=1 in the same cycle, conv_pend set.
  - btn_run -> ST_PAUSE.
  - Terminal count: tick with count_in==MAX_COUNT. If WRAP=1, cnt_clr is pulsed instead of cnt_en. If WRAP=0, no pulse is issued and the FSM goes to ST_HALT.
- ST_PAUSE:
  - btn_run -> ST_RUN.
  - Each tick toggles a blink bit; disp_blank = blink bit.
- ST_HALT:
  - Blinks as in ST_PAUSE.
  - btn_run ignored.
  - Only btn_clear exits.
- btn_clear, in any state:
  - cnt_clr=1 for one cycle, conv_pend set, conv_err cleared, frozen cleared, blink cleared.
  - Next state ST_IDLE.
- Priority in the same cycle: btn_clear > btn_run > tick.
  - A tick coincident with btn_clear issues no cnt_en.
  - A tick coincident with btn_run: btn_run takes effect, and the tick is acted on only if the state before the transition was ST_RUN.
- cnt_en and cnt_clr are never asserted together.
- disp_blank=0 in ST_IDLE and ST_RUN.
- Conv FSM states: CV_IDLE, CV_LAUNCH, CV_WAIT.
  - CV_IDLE: conv_pend=1 -> CV_LAUNCH. This adds one cycle so count_in reflects the counter update.
  - CV_LAUNCH: conv_bin<=count_in, conv_start=1, conv_pend cleared, timer=0 -> CV_WAIT.
  - CV_WAIT, on conv_done: result register <= conv_bcd; disp_bcd updated next cycle unless frozen -> CV_IDLE.
  - CV_WAIT, when timer reaches CONV_TIMEOUT without conv_done: conv_err=1, result discarded -> CV_IDLE.
  - Any new conv_pend raised during CV_WAIT is coalesced into one re-conversion of the latest value.
- Latency: tick to conv_start is 2 cycles; conv_done to disp_bcd is 1 cycle.
- Lap (btn_lap):
  - Toggles frozen. While frozen, disp_bcd holds its value; conversions continue.
  - On unfreeze, disp_bcd loads the latest completed result the next cycle.
  - btn_lap coincident with btn_clear is ignored.

Decomposition:
- Package ctr_ctrl_pkg: main/conv state encodings, BCD_W=16, default MAX_COUNT and CONV_TIMEOUT.
- One sub-module, conv_sequencer: conv FSM, pending flag, timeout timer, result register, conv_err.
- Top level: main FSM, blink, freeze, display mux.

Test Plan:
- Release rst, no buttons -> exactly one conv_start with conv_bin=0; after conv_done(bcd=0x0000), disp_bcd=0x0000, disp_blank=0.
- btn_run, 3 ticks, converter done after 13 cycles -> 3 cnt_en pulses, each followed by conv_start 2 cycles later; disp_bcd=0x0003.
- count_in=4095 in ST_RUN, tick: WRAP=1 -> cnt_clr pulse, no cnt_en, running stays 1. WRAP=0 -> no pulse, ST_HALT, disp_blank toggles per tick, btn_run ignored.
- btn_lap at 0x0005, 4 more ticks -> disp_bcd stays 0x0005; second btn_lap -> disp_bcd=0x0009 next cycle.
- btn_clear, btn_run and tick in the same cycle while running -> cnt_clr only, no cnt_en, state ST_IDLE, frozen=0.
- conv_done withheld -> conv_err=1 exactly CONV_TIMEOUT cycles after conv_start, disp_bcd unchanged; btn_clear -> conv_err=0.

Source files
------------

// File: rtl/ctr_ctrl_pkg.sv
// Shared encodings and defaults for the counter run controller and its
// converter sequencer.
package ctr_ctrl_pkg;

  localparam int BCD_W            = 16;
  localparam int DEF_WIDTH        = 12;
  localparam int DEF_MAX_COUNT    = 4095;
  localparam int DEF_CONV_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_HALT
  } main_state_t;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_LAUNCH,
    CV_WAIT
  } conv_state_t;

endpackage

// File: rtl/conv_sequencer.sv
// Drives the multi-cycle binary-to-BCD converter: coalesces conversion
// requests, launches with a held operand, and aborts on timeout.
//
// state     | meaning
// CV_IDLE   | no conversion in flight; leaves when a request is pending
// CV_LAUNCH | conv_start high, operand stable on conv_bin
// CV_WAIT   | waiting for conv_done, timeout timer counting down
module conv_sequencer
  import ctr_ctrl_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CONV_TIMEOUT = DEF_CONV_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pend_set,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] count_in,
  input  logic             conv_done,
  input  logic [BCD_W-1:0] conv_bcd,
  output logic             conv_start,
  output logic [WIDTH-1:0] conv_bin,
  output logic             res_strobe,
  output logic [BCD_W-1:0] result,
  output logic             conv_err
);

  localparam int TW = $clog2(CONV_TIMEOUT + 1);

  conv_state_t   state, state_nxt;
  logic          conv_pend;
  logic          launch;
  logic          timeout;
  logic [TW-1:0] timer;

  assign launch     = (state == CV_IDLE) && conv_pend;
  assign conv_start = (state == CV_LAUNCH);
  assign res_strobe = (state == CV_WAIT) && conv_done;
  // Timer is loaded in CV_LAUNCH so that terminal count lands on the cycle
  // that makes conv_err visible exactly CONV_TIMEOUT cycles after conv_start.
  assign timeout    = (state == CV_WAIT) && !conv_done && (timer == TW'(1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      CV_IDLE:   if (conv_pend) state_nxt = CV_LAUNCH;
      CV_LAUNCH: state_nxt = CV_WAIT;
      CV_WAIT:   if (conv_done || timeout) state_nxt = CV_IDLE;
      default:   state_nxt = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CV_IDLE;
      conv_pend <= 1'b1;
      timer     <= '0;
      conv_bin  <= '0;
      result    <= '0;
      conv_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      // A request arriving while one is consumed wins, so it is never lost.
      if (pend_set)    conv_pend <= 1'b1;
      else if (launch) conv_pend <= 1'b0;
      if (launch) conv_bin <= count_in;
      if (state == CV_LAUNCH)
        timer <= TW'(CONV_TIMEOUT - 1);
      else if ((state == CV_WAIT) && (timer != '0))
        timer <= timer - TW'(1);
      if (res_strobe) result <= conv_bcd;
      if (err_clr)      conv_err <= 1'b0;
      else if (timeout) conv_err <= 1'b1;
    end
  end

endmodule

// File: rtl/counter_run_controller.sv
// Run/pause/clear/lap control for the counter display path; owns the
// displayed BCD value and hands conversions to conv_sequencer.
//
// state    | meaning
// ST_IDLE  | stopped after reset or clear, ticks ignored
// ST_RUN   | ticks increment the counter
// ST_PAUSE | stopped by btn_run, display blinks on ticks
// ST_HALT  | stopped at terminal count (no-wrap build), only clear exits
module counter_run_controller
  import ctr_ctrl_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int MAX_COUNT    = DEF_MAX_COUNT,
  parameter bit WRAP         = 1'b1,
  parameter int CONV_TIMEOUT = DEF_CONV_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn_run,
  input  logic             btn_clear,
  input  logic             btn_lap,
  input  logic [WIDTH-1:0] count_in,
  input  logic             conv_done,
  input  logic [BCD_W-1:0] conv_bcd,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             conv_start,
  output logic [WIDTH-1:0] conv_bin,
  output logic [BCD_W-1:0] disp_bcd,
  output logic             disp_blank,
  output logic             running,
  output logic             frozen,
  output logic             conv_err
);

  main_state_t      state, state_nxt;
  logic             blink, blink_nxt;
  logic             frozen_nxt;
  logic             at_max;
  logic             res_strobe;
  logic [BCD_W-1:0] result;

  assign at_max     = (count_in == WIDTH'(MAX_COUNT));
  assign running    = (state == ST_RUN);
  assign disp_blank = blink && ((state == ST_PAUSE) || (state == ST_HALT));

  always_comb begin
    state_nxt  = state;
    blink_nxt  = blink;
    frozen_nxt = frozen ^ btn_lap;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    if (btn_clear) begin
      state_nxt  = ST_IDLE;
      blink_nxt  = 1'b0;
      frozen_nxt = 1'b0;
      cnt_clr    = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: if (btn_run) state_nxt = ST_RUN;
        ST_RUN: begin
          if (btn_run) state_nxt = ST_PAUSE;
          if (tick) begin
            if (!at_max)      cnt_en    = 1'b1;
            else if (WRAP)    cnt_clr   = 1'b1;
            else if (!btn_run) state_nxt = ST_HALT;
          end
        end
        ST_PAUSE: begin
          // Leaving pause clears blink so RUN always shows the display.
          if (btn_run) begin
            state_nxt = ST_RUN;
            blink_nxt = 1'b0;
          end else if (tick) begin
            blink_nxt = !blink;
          end
        end
        ST_HALT: if (tick) blink_nxt = !blink;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      blink    <= 1'b0;
      frozen   <= 1'b0;
      disp_bcd <= '0;
    end else begin
      state  <= state_nxt;
      blink  <= blink_nxt;
      frozen <= frozen_nxt;
      if (!frozen && res_strobe)
        disp_bcd <= conv_bcd;
      else if (frozen && !frozen_nxt)
        disp_bcd <= res_strobe ? conv_bcd : result;
    end
  end

  conv_sequencer #(
    .WIDTH        (WIDTH),
    .CONV_TIMEOUT (CONV_TIMEOUT)
  ) u_conv (
    .clk        (clk),
    .rst        (rst),
    .pend_set   (cnt_en | cnt_clr),
    .err_clr    (btn_clear),
    .count_in   (count_in),
    .conv_done  (conv_done),
    .conv_bcd   (conv_bcd),
    .conv_start (conv_start),
    .conv_bin   (conv_bin),
    .res_strobe (res_strobe),
    .result     (result),
    .conv_err   (conv_err)
  );

endmodule

// File: tb/tb_counter_run_controller.sv
// Directed bench: a wrapping and a halting instance share stimulus; the bench
// plays the up counter and the converter by hand.
module tb_counter_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0, btn_run = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
  logic        conv_done = 1'b0;
  logic [11:0] count_in = '0;
  logic [15:0] conv_bcd = '0;

  logic        cnt_en, cnt_clr, conv_start, disp_blank, running, frozen, conv_err;
  logic [11:0] conv_bin;
  logic [15:0] disp_bcd;
  logic        h_en, h_clr, h_start, h_blank, h_running, h_frozen, h_err;
  logic [11:0] h_bin;
  logic [15:0] h_disp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_run_controller u_dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_run(btn_run), .btn_clear(btn_clear),
    .btn_lap(btn_lap), .count_in(count_in), .conv_done(conv_done), .conv_bcd(conv_bcd),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .conv_start(conv_start), .conv_bin(conv_bin),
    .disp_bcd(disp_bcd), .disp_blank(disp_blank), .running(running), .frozen(frozen),
    .conv_err(conv_err)
  );

  counter_run_controller #(.WRAP(1'b0)) u_halt (
    .clk(clk), .rst(rst), .tick(tick), .btn_run(btn_run), .btn_clear(btn_clear),
    .btn_lap(btn_lap), .count_in(count_in), .conv_done(conv_done), .conv_bcd(conv_bcd),
    .cnt_en(h_en), .cnt_clr(h_clr), .conv_start(h_start), .conv_bin(h_bin),
    .disp_bcd(h_disp), .disp_blank(h_blank), .running(h_running), .frozen(h_frozen),
    .conv_err(h_err)
  );

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max_cyc, output int waited);
    waited = 0;
    while (conv_start !== 1'b1 && waited < max_cyc) begin
      step();
      waited++;
    end
    if (conv_start !== 1'b1) waited = -1;
  endtask

  task automatic convert(input int lat, input logic [15:0] bcd);
    repeat (lat) step();
    conv_done = 1'b1;
    conv_bcd  = bcd;
    step();
    conv_done = 1'b0;
  endtask

  // One tick while running: emulates the counter, then services the conversion.
  task automatic tick_conv(input int lat, output logic [1:0] pulses, output int start_lat);
    int w;
    tick = 1'b1;
    #1 pulses = {cnt_en, cnt_clr};
    step();
    tick = 1'b0;
    count_in = count_in + 12'd1;
    wait_start(8, w);
    if (w < 0) start_lat = -1;
    else begin
      start_lat = w + 1;
      convert(lat, to_bcd(int'(count_in)));
    end
  endtask

  task automatic test_reset();
    int w;
    int extra;
    rst = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({cnt_en, cnt_clr, conv_start, disp_blank, running, frozen, conv_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, want 0000000",
        {cnt_en, cnt_clr, conv_start, disp_blank, running, frozen, conv_err});
    end
    n_checks++;
    if ({disp_bcd, conv_bin, h_disp, h_bin, h_start} !== 57'h0) begin
      n_fail++; $display("FAIL reset_data: disp=%h bin=%h hdisp=%h hbin=%h hstart=%b, want all 0",
        disp_bcd, conv_bin, h_disp, h_bin, h_start);
    end
    rst = 1'b1;
    wait_start(4, w);
    n_checks++;
    if (w !== 1) begin n_fail++; $display("FAIL reset_first_start: got %0d cycles, want 1", w); end
    n_checks++;
    if (conv_bin !== 12'h000) begin n_fail++; $display("FAIL reset_conv_bin: got %h, want 000", conv_bin); end
    if (w >= 0) convert(1, 16'h0000);
    n_checks++;
    if ({disp_bcd, disp_blank} !== 17'h0) begin
      n_fail++; $display("FAIL reset_disp: got disp=%h blank=%b, want 0000/0", disp_bcd, disp_blank);
    end
    extra = 0;
    repeat (6) begin
      step();
      if (conv_start === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL reset_single_start: got %0d extra starts, want 0", extra); end
  endtask

  task automatic test_count();
    logic [1:0] p;
    int lat;
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL count_running: got %b, want 1", running); end
    for (int i = 1; i <= 3; i++) begin
      tick_conv(13, p, lat);
      n_checks++;
      if (p !== 2'b10) begin n_fail++; $display("FAIL count_pulse%0d: got en,clr=%b, want 10", i, p); end
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL count_start_lat%0d: got %0d, want 2", i, lat); end
      n_checks++;
      if (disp_bcd !== to_bcd(i)) begin
        n_fail++; $display("FAIL count_disp%0d: got %h, want %h", i, disp_bcd, to_bcd(i));
      end
    end
  endtask

  task automatic test_lap();
    logic [1:0] p;
    int lat;
    repeat (2) tick_conv(3, p, lat);
    n_checks++;
    if (disp_bcd !== 16'h0005) begin n_fail++; $display("FAIL lap_pre: got %h, want 0005", disp_bcd); end
    btn_lap = 1'b1;
    step();
    btn_lap = 1'b0;
    n_checks++;
    if (frozen !== 1'b1) begin n_fail++; $display("FAIL lap_frozen: got %b, want 1", frozen); end
    for (int i = 6; i <= 9; i++) begin
      tick_conv(3, p, lat);
      n_checks++;
      if (disp_bcd !== 16'h0005) begin
        n_fail++; $display("FAIL lap_hold%0d: got %h, want 0005", i, disp_bcd);
      end
    end
    btn_lap = 1'b1;
    step();
    btn_lap = 1'b0;
    n_checks++;
    if ({frozen, disp_bcd} !== {1'b0, 16'h0009}) begin
      n_fail++; $display("FAIL lap_release: got frozen=%b disp=%h, want 0/0009", frozen, disp_bcd);
    end
  endtask

  task automatic test_terminal();
    logic [1:0] p;
    logic       exp_blink;
    int lat;
    int w;
    count_in = 12'd4095;
    tick = 1'b1;
    #1;
    n_checks++;
    if ({cnt_en, cnt_clr, h_en, h_clr} !== 4'b0100) begin
      n_fail++; $display("FAIL term_pulses: got wrap en,clr=%b%b halt en,clr=%b%b, want 01 00",
        cnt_en, cnt_clr, h_en, h_clr);
    end
    step();
    tick = 1'b0;
    count_in = 12'd0;
    n_checks++;
    if ({running, h_running, h_blank} !== 3'b100) begin
      n_fail++; $display("FAIL term_state: got run=%b hrun=%b hblank=%b, want 1 0 0",
        running, h_running, h_blank);
    end
    wait_start(8, w);
    if (w >= 0) convert(2, 16'h0000);
    exp_blink = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick_conv(2, p, lat);
      exp_blink = ~exp_blink;
      n_checks++;
      if (h_blank !== exp_blink) begin
        n_fail++; $display("FAIL halt_blink%0d: got %b, want %b", i, h_blank, exp_blink);
      end
    end
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    n_checks++;
    if ({running, h_running} !== 2'b00) begin
      n_fail++; $display("FAIL pause_enter: got run=%b hrun=%b, want 0 0", running, h_running);
    end
    tick = 1'b1;
    #1;
    n_checks++;
    if ({cnt_en, cnt_clr, h_en, h_clr} !== 4'b0000) begin
      n_fail++; $display("FAIL pause_tick_pulse: got %b, want 0000", {cnt_en, cnt_clr, h_en, h_clr});
    end
    step();
    tick = 1'b0;
    n_checks++;
    if ({disp_blank, h_blank} !== 2'b11) begin
      n_fail++; $display("FAIL pause_blink: got blank=%b hblank=%b, want 1 1", disp_blank, h_blank);
    end
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    n_checks++;
    if ({running, disp_blank, h_running} !== 3'b100) begin
      n_fail++; $display("FAIL resume: got run=%b blank=%b hrun=%b, want 1 0 0",
        running, disp_blank, h_running);
    end
  endtask

  task automatic test_clear();
    int w;
    btn_lap = 1'b1;
    step();
    btn_lap = 1'b0;
    n_checks++;
    if (frozen !== 1'b1) begin n_fail++; $display("FAIL clear_prefreeze: got %b, want 1", frozen); end
    btn_clear = 1'b1; btn_run = 1'b1; tick = 1'b1; btn_lap = 1'b1;
    #1;
    n_checks++;
    if ({cnt_en, cnt_clr} !== 2'b01) begin
      n_fail++; $display("FAIL clear_pulses: got en,clr=%b%b, want 01", cnt_en, cnt_clr);
    end
    step();
    btn_clear = 1'b0; btn_run = 1'b0; tick = 1'b0; btn_lap = 1'b0;
    count_in = 12'd0;
    n_checks++;
    if ({running, frozen, disp_blank, h_running, h_frozen, h_blank} !== 6'b0) begin
      n_fail++; $display("FAIL clear_state: got %b, want 000000",
        {running, frozen, disp_blank, h_running, h_frozen, h_blank});
    end
    tick = 1'b1;
    #1;
    n_checks++;
    if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL clear_idle_tick: got %b, want 0", cnt_en); end
    step();
    tick = 1'b0;
    wait_start(8, w);
    n_checks++;
    if (w < 0) begin n_fail++; $display("FAIL clear_reconvert: got no conv_start, want one"); end
    else convert(2, 16'h0000);
    n_checks++;
    if (disp_bcd !== 16'h0000) begin n_fail++; $display("FAIL clear_disp: got %h, want 0000", disp_bcd); end
  endtask

  task automatic test_timeout();
    int w;
    int n;
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    count_in = 12'd1;
    wait_start(8, w);
    n_checks++;
    if (w !== 1) begin n_fail++; $display("FAIL to_start: got %0d, want 1", w); end
    n = 0;
    while (conv_err !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    n_checks++;
    if (n !== 64) begin n_fail++; $display("FAIL to_cycles: got %0d, want 64", n); end
    n_checks++;
    if ({h_err, disp_bcd} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL to_flags: got herr=%b disp=%h, want 1/0000", h_err, disp_bcd);
    end
    conv_done = 1'b1;
    conv_bcd  = 16'h1234;
    step();
    conv_done = 1'b0;
    step();
    n_checks++;
    if (disp_bcd !== 16'h0000) begin n_fail++; $display("FAIL to_late_done: got %h, want 0000", disp_bcd); end
    btn_clear = 1'b1;
    step();
    btn_clear = 1'b0;
    n_checks++;
    if ({conv_err, h_err} !== 2'b00) begin
      n_fail++; $display("FAIL to_clear: got err=%b herr=%b, want 0 0", conv_err, h_err);
    end
    wait_start(8, w);
    if (w >= 0) convert(1, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_count();
    test_lap();
    test_terminal();
    test_clear();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
